fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles allowed from request acceptance to response.
REQ-002 Port i_clk  input  1  single clock; all logic on rising edge.
REQ-003 Port i_rst  input  1  reset, synchronous, active-high.
REQ-004 Port i_next_instr_addr  input  64 [0:63]  next instruction address from the branch facility.
REQ-005 Port o_stall  output  1  to branch facility; 0 only in the cycle an instruction is consumed.
REQ-006 Port o_fetch_req_valid  output  1  fetch request valid.
REQ-007 Port o_fetch_req_addr  output  64 [0:63]  fetch address.
REQ-008 Port i_fetch_req_ready  input  1  memory accepts request.
REQ-009 Port i_fetch_rsp_valid  input  1  response valid (single cycle, no backpressure).
REQ-010 Port i_fetch_rsp_instr  input  32 [0:31]  fetched instruction.
REQ-011 Port i_fetch_rsp_err  input  1  bus error, qualified by rsp_valid.
REQ-012 Port o_instr_valid  output  1  instruction valid toward instruction identify.
REQ-013 Port o_instr  output  32 [0:31]  held instruction.
REQ-014 Port o_instr_addr  output  64 [0:63]  address of o_instr.
REQ-015 Port i_instr_ready  input  1  consumer accepts instruction.
REQ-016 Port o_halted  output  1  sequencer stopped on error.
REQ-017 Port o_err_code  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
REQ-018 Port o_retired_count  output  64  instructions consumed since reset.

Function
REQ-019 FSM states: BOOT, REQ, WAIT, DELIVER, HALT.
REQ-020 BOOT: lasts exactly one cycle after reset, no request issued, then goes to REQ.
REQ-021 Internal pc register; o_fetch_req_addr = pc; o_instr_addr = pc.
REQ-022 REQ: if pc[62:63] != 00 -> HALT with code 01, no request issued; else o_fetch_req_valid=1.
REQ-023 REQ -> WAIT on valid&ready; valid and addr held stable until ready.
REQ-024 At most one outstanding request; o_fetch_req_valid=0 outside REQ.
REQ-025 WAIT: timeout counter cleared on entry, incremented each cycle without a response; response valid with err=0 -> capture instr, go DELIVER; err=1 -> HALT code 10.
REQ-026 WAIT: counter reaching TIMEOUT_CYCLES without a response -> HALT code 11; a response in that same cycle takes priority over timeout.
REQ-027 DELIVER: o_instr_valid=1, o_instr stable until handshake.
REQ-028 Handshake (o_instr_valid & i_instr_ready): pc <= i_next_instr_addr, o_retired_count += 1 (wraps modulo 2^64), next state REQ.
REQ-029 o_stall = ~(o_instr_valid & i_instr_ready), combinational; 1 in all other states, including BOOT and HALT.
REQ-030 Minimum throughput: 3 cycles per instruction (REQ, WAIT, DELIVER) with zero-latency memory.
REQ-031 Responses arriving outside WAIT are ignored; no state change.
REQ-032 HALT: terminal until reset; o_halted=1, o_err_code holds the first error only, no requests, o_instr_valid=0.

Reset
REQ-033 On i_rst: state=BOOT, pc=0, o_instr=0, timeout counter=0, o_retired_count=0, o_err_code=00, o_halted=0, all valids 0, o_stall=1.
REQ-034 Reset mid-operation (any state) abandons outstanding request and held instruction; reset has priority over every other event in the same cycle.

Structure
REQ-035 Shared package fetch_pkg holds the state enum, the 2-bit error-code typedef with named values, and the address-width constant (64).
REQ-036 Single module; no sub-module; timeout counter width = $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-037 Reset, memory ready=1, response 1 cycle later with instr 0x60000000; consumer ready=1 -> first request addr 0 in cycle 2 after reset; o_stall=0 for exactly one cycle; retired_count=1.
REQ-038 i_next_instr_addr=0x1000 at handshake -> next o_fetch_req_addr=0x1000; memory ready held 0 for 5 cycles -> valid and addr stable throughout.
REQ-039 i_next_instr_addr=0x1002 at handshake -> HALT, err_code=01, no request issued, o_stall stays 1.
REQ-040 Response with err=1 -> HALT, err_code=10; later timeout or spurious response does not change code.
REQ-041 TIMEOUT_CYCLES=4, no response -> err_code=11 after 4 WAIT cycles; response in that exact cycle -> DELIVER, no error.
REQ-042 Consumer ready=0 for 3 cycles in DELIVER, then i_rst=1 -> o_instr_valid=0 next cycle, state BOOT, retired_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Addresses and instructions use big-endian bit numbering (bit 0 is the MSB).
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    // Instructions are 4-byte aligned: the two least significant bits must be zero.
    function automatic logic is_word_aligned(input logic [0:ADDR_W-1] addr);
        return (addr[ADDR_W-2:ADDR_W-1] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the returned
// instruction for the consumer, and stops permanently on the first error.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [0:ADDR_W-1]   i_next_instr_addr,
    output logic                o_stall,
    output logic                o_fetch_req_valid,
    output logic [0:ADDR_W-1]   o_fetch_req_addr,
    input  logic                i_fetch_req_ready,
    input  logic                i_fetch_rsp_valid,
    input  logic [0:INSTR_W-1]  i_fetch_rsp_instr,
    input  logic                i_fetch_rsp_err,
    output logic                o_instr_valid,
    output logic [0:INSTR_W-1]  o_instr,
    output logic [0:ADDR_W-1]   o_instr_addr,
    input  logic                i_instr_ready,
    output logic                o_halted,
    output logic [1:0]          o_err_code,
    output logic [63:0]         o_retired_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [0:ADDR_W-1]  pc_r;
    logic [0:ADDR_W-1]  pc_nxt_s;
    logic [0:INSTR_W-1] instr_r;
    logic [0:INSTR_W-1] instr_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [63:0]        retired_r;
    logic [63:0]        retired_nxt_s;
    err_code_e          err_r;
    err_code_e          err_nxt_s;
    logic               req_valid_s;
    logic               instr_valid_s;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // State and datapath registers; reset outranks every other event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_BOOT;
            pc_r      <= {ADDR_W{1'b0}};
            instr_r   <= {INSTR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            retired_r <= 64'd0;
            err_r     <= ERR_NONE;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            instr_r   <= instr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            retired_r <= retired_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // Next-state, datapath updates and handshake qualifiers.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        instr_nxt_s   = instr_r;
        cnt_nxt_s     = cnt_r;
        retired_nxt_s = retired_r;
        err_nxt_s     = err_r;
        req_valid_s   = 1'b0;
        instr_valid_s = 1'b0;

        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (!is_word_aligned(pc_r)) begin
                    state_nxt_s = ST_HALT;
                    err_nxt_s   = ERR_MISALIGN;
                end else begin
                    req_valid_s = 1'b1;
                    if (i_fetch_req_ready) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
            end
            ST_WAIT: begin
                // A response in the final counted cycle still wins over the timeout.
                if (i_fetch_rsp_valid) begin
                    if (i_fetch_rsp_err) begin
                        state_nxt_s = ST_HALT;
                        err_nxt_s   = ERR_BUS;
                    end else begin
                        state_nxt_s = ST_DELIVER;
                        instr_nxt_s = i_fetch_rsp_instr;
                    end
                end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_nxt_s   = cnt_inc_s;
                    state_nxt_s = ST_HALT;
                    err_nxt_s   = ERR_TIMEOUT;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_DELIVER: begin
                instr_valid_s = 1'b1;
                if (i_instr_ready) begin
                    state_nxt_s   = ST_REQ;
                    pc_nxt_s      = i_next_instr_addr;
                    retired_nxt_s = retired_r + 64'd1;
                end else begin
                    state_nxt_s = ST_DELIVER;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    assign o_stall           = ~(instr_valid_s & i_instr_ready);
    assign o_fetch_req_valid = req_valid_s;
    assign o_fetch_req_addr  = pc_r;
    assign o_instr_valid     = instr_valid_s;
    assign o_instr           = instr_r;
    assign o_instr_addr      = pc_r;
    assign o_halted          = (state_r == ST_HALT);
    assign o_err_code        = err_r;
    assign o_retired_count   = retired_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-level reference model checked on
// every falling edge, plus literal expectations at key points of each scenario.
module tb_fetch_sequencer;

    localparam int T = 4;

    logic        i_clk;
    logic        i_rst;
    logic [0:63] i_next_instr_addr;
    logic        o_stall;
    logic        o_fetch_req_valid;
    logic [0:63] o_fetch_req_addr;
    logic        i_fetch_req_ready;
    logic        i_fetch_rsp_valid;
    logic [0:31] i_fetch_rsp_instr;
    logic        i_fetch_rsp_err;
    logic        o_instr_valid;
    logic [0:31] o_instr;
    logic [0:63] o_instr_addr;
    logic        i_instr_ready;
    logic        o_halted;
    logic [1:0]  o_err_code;
    logic [63:0] o_retired_count;

    int n_checks    = 0;
    int n_errors    = 0;
    int n_stall_low = 0;
    int stall_mark;

    fetch_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_next_instr_addr (i_next_instr_addr),
        .o_stall           (o_stall),
        .o_fetch_req_valid (o_fetch_req_valid),
        .o_fetch_req_addr  (o_fetch_req_addr),
        .i_fetch_req_ready (i_fetch_req_ready),
        .i_fetch_rsp_valid (i_fetch_rsp_valid),
        .i_fetch_rsp_instr (i_fetch_rsp_instr),
        .i_fetch_rsp_err   (i_fetch_rsp_err),
        .o_instr_valid     (o_instr_valid),
        .o_instr           (o_instr),
        .o_instr_addr      (o_instr_addr),
        .i_instr_ready     (i_instr_ready),
        .o_halted          (o_halted),
        .o_err_code        (o_err_code),
        .o_retired_count   (o_retired_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the sequencer is doing, in terms of pending work.
    bit          m_known   = 1'b0;
    bit          m_boot    = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_waiting = 1'b0;
    bit          m_holding = 1'b0;
    bit          m_halted  = 1'b0;
    int          m_wait_n  = 0;
    logic [1:0]  m_err     = 2'b00;
    logic [63:0] m_pc      = 64'd0;
    logic [63:0] m_retired = 64'd0;
    logic [31:0] m_instr   = 32'd0;

    // Compare against the model, then advance it with the inputs the next edge will sample.
    always @(negedge i_clk) begin
        if (o_stall === 1'b0) n_stall_low++;
        if (m_known) begin
            check("req_valid",   64'(o_fetch_req_valid), 64'(m_pending && !m_halted && (m_pc[1:0] == 2'b00)));
            check("req_addr",    o_fetch_req_addr, m_pc);
            check("instr_addr",  o_instr_addr, m_pc);
            check("instr_valid", 64'(o_instr_valid), 64'(m_holding));
            check("instr",       64'(o_instr), 64'(m_instr));
            check("stall",       64'(o_stall), 64'(!(m_holding && i_instr_ready)));
            check("halted",      64'(o_halted), 64'(m_halted));
            check("err_code",    64'(o_err_code), 64'(m_err));
            check("retired",     o_retired_count, m_retired);
        end
        if (i_rst) begin
            m_known = 1'b1; m_boot = 1'b1; m_pending = 1'b0; m_waiting = 1'b0;
            m_holding = 1'b0; m_halted = 1'b0; m_wait_n = 0; m_err = 2'b00;
            m_pc = 64'd0; m_retired = 64'd0; m_instr = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pending = 1'b1;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_pending) begin
            if (m_pc % 64'd4 != 64'd0) begin
                m_halted = 1'b1; m_err = 2'b01; m_pending = 1'b0;
            end else if (i_fetch_req_ready) begin
                m_pending = 1'b0; m_waiting = 1'b1; m_wait_n = 0;
            end
        end else if (m_waiting) begin
            if (i_fetch_rsp_valid) begin
                m_waiting = 1'b0;
                if (i_fetch_rsp_err) begin
                    m_halted = 1'b1; m_err = 2'b10;
                end else begin
                    m_holding = 1'b1; m_instr = i_fetch_rsp_instr;
                end
            end else begin
                m_wait_n++;
                if (m_wait_n == T) begin
                    m_waiting = 1'b0; m_halted = 1'b1; m_err = 2'b11;
                end
            end
        end else if (m_holding && i_instr_ready) begin
            m_holding = 1'b0; m_pending = 1'b1;
            m_pc = i_next_instr_addr; m_retired = m_retired + 64'd1;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rst = 1'b0; i_fetch_req_ready = 1'b0; i_fetch_rsp_valid = 1'b0;
        i_fetch_rsp_instr = 32'd0; i_fetch_rsp_err = 1'b0; i_instr_ready = 1'b0;
    endtask

    // Reset, check the boot cycle, and stop at the first request cycle.
    task automatic reset_to_req();
        idle_inputs();
        i_rst = 1'b1;
        tick();
        check("boot_req_valid", 64'(o_fetch_req_valid), 64'd0);
        check("boot_stall",     64'(o_stall), 64'd1);
        check("boot_halted",    64'(o_halted), 64'd0);
        check("boot_err",       64'(o_err_code), 64'd0);
        check("boot_retired",   o_retired_count, 64'd0);
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b1;
        i_next_instr_addr = 64'd0;
        tick();
        tick();

        // First instruction with zero-latency memory and an always-ready consumer.
        stall_mark = n_stall_low;
        reset_to_req();
        check("first_req_valid", 64'(o_fetch_req_valid), 64'd1);
        check("first_req_addr",  o_fetch_req_addr, 64'd0);
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_instr = 32'h6000_0000;
        tick();
        i_fetch_rsp_valid = 1'b0;
        i_instr_ready = 1'b1;
        i_next_instr_addr = 64'h1000;
        #1;
        check("deliver_stall", 64'(o_stall), 64'd0);
        check("deliver_instr", 64'(o_instr), 64'h6000_0000);
        tick();
        i_instr_ready = 1'b0;
        check("after_hs_stall",   64'(o_stall), 64'd1);
        check("after_hs_retired", o_retired_count, 64'd1);
        check("next_req_addr",    o_fetch_req_addr, 64'h1000);
        check("stall_low_cycles", 64'(n_stall_low - stall_mark), 64'd1);

        // Memory not ready for five cycles: request must hold.
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(o_fetch_req_valid), 64'd1);
            check("hold_addr",  o_fetch_req_addr, 64'h1000);
            tick();
        end
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_instr = 32'h1234_5678;
        tick();
        i_fetch_rsp_valid = 1'b0;
        check("second_instr",      64'(o_instr), 64'h1234_5678);
        check("second_instr_addr", o_instr_addr, 64'h1000);
        i_instr_ready = 1'b1;
        i_next_instr_addr = 64'h1002;
        tick();
        i_instr_ready = 1'b0;

        // Misaligned next address: no request, halt with code 01.
        check("misalign_req_valid", 64'(o_fetch_req_valid), 64'd0);
        check("misalign_stall",     64'(o_stall), 64'd1);
        tick();
        check("misalign_halted", 64'(o_halted), 64'd1);
        check("misalign_code",   64'(o_err_code), 64'd1);
        check("misalign_retired", o_retired_count, 64'd2);
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_err = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("misalign_code_kept", 64'(o_err_code), 64'd1);

        // Bus error, then no timeout and a spurious response must not disturb it.
        reset_to_req();
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_err = 1'b1;
        tick();
        idle_inputs();
        check("bus_halted", 64'(o_halted), 64'd1);
        check("bus_code",   64'(o_err_code), 64'd2);
        repeat (6) tick();
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_instr = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check("bus_code_kept",   64'(o_err_code), 64'd2);
        check("bus_no_capture",  64'(o_instr), 64'd0);
        check("bus_instr_valid", 64'(o_instr_valid), 64'd0);

        // Timeout after exactly T waiting cycles.
        reset_to_req();
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        repeat (T - 1) tick();
        check("pre_timeout_halted", 64'(o_halted), 64'd0);
        tick();
        check("timeout_halted", 64'(o_halted), 64'd1);
        check("timeout_code",   64'(o_err_code), 64'd3);

        // Response in the last waiting cycle beats the timeout.
        reset_to_req();
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        repeat (T - 1) tick();
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_instr = 32'hA5A5_0001;
        tick();
        i_fetch_rsp_valid = 1'b0;
        check("late_rsp_halted", 64'(o_halted), 64'd0);
        check("late_rsp_code",   64'(o_err_code), 64'd0);
        check("late_rsp_valid",  64'(o_instr_valid), 64'd1);
        check("late_rsp_instr",  64'(o_instr), 64'hA5A5_0001);

        // Retire it, stall the next one in delivery, then reset with the consumer ready.
        i_instr_ready = 1'b1;
        i_next_instr_addr = 64'h40;
        tick();
        i_instr_ready = 1'b0;
        i_fetch_req_ready = 1'b1;
        tick();
        i_fetch_req_ready = 1'b0;
        i_fetch_rsp_valid = 1'b1;
        i_fetch_rsp_instr = 32'h0BAD_F00D;
        tick();
        i_fetch_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("held_valid", 64'(o_instr_valid), 64'd1);
            check("held_stall", 64'(o_stall), 64'd1);
            tick();
        end
        check("held_retired", o_retired_count, 64'd1);
        i_rst = 1'b1;
        i_instr_ready = 1'b1;
        tick();
        check("rst_instr_valid", 64'(o_instr_valid), 64'd0);
        check("rst_retired",     o_retired_count, 64'd0);
        check("rst_instr",       64'(o_instr), 64'd0);
        check("rst_req_valid",   64'(o_fetch_req_valid), 64'd0);
        idle_inputs();
        tick();
        check("rst_req_again",  64'(o_fetch_req_valid), 64'd1);
        check("rst_req_addr",   o_fetch_req_addr, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
